// File: rtl/lcd_refresh_master.sv
// Avalon-MM master for a character LCD: HD44780-timed accesses, power-on init,
// and continuous refresh of a 2x16 text buffer with busy polling after every write.
module lcd_refresh_master #(
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned E_CYCLES       = 12,
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned POWERON_CYCLES = 750000,
  parameter int unsigned POLL_LIMIT     = 4095
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [1:0] avm_address,
  output logic       avm_read,
  output logic       avm_write,
  output logic       avm_begintransfer,
  output logic [7:0] avm_writedata,
  input  logic [7:0] avm_readdata,
  input  logic       buf_we,
  input  logic [4:0] buf_addr,
  input  logic [7:0] buf_wdata,
  output logic       init_done,
  output logic       timeout_err,
  output logic       frame_done
);

  localparam int unsigned MAX_PH = (E_CYCLES > SETUP_CYCLES) ?
                                   ((E_CYCLES > HOLD_CYCLES) ? E_CYCLES : HOLD_CYCLES) :
                                   ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES);
  localparam int unsigned PH_W = $clog2(MAX_PH + 1);
  localparam int unsigned PW_W = $clog2(POWERON_CYCLES + 1);
  localparam int unsigned PL_W = $clog2(POLL_LIMIT + 1);

  localparam logic [1:0] ADDR_CMD    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DATA   = 2'b10;

  typedef enum logic [2:0] {PWR_WAIT, INIT, POLL, LINE_ADDR, DATA, FRAME} state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} phase_e;

  state_e          state_q, state_d, caller_q, caller_d;
  phase_e          phase_q, phase_d;
  logic [PH_W-1:0] pcnt_q, pcnt_d;
  logic [PW_W-1:0] pw_cnt_q, pw_cnt_d;
  logic [PL_W-1:0] poll_cnt_q, poll_cnt_d;
  logic [1:0]      init_idx_q, init_idx_d;
  logic            line_q, line_d;
  logic [3:0]      col_q, col_d;
  logic            busy_q, busy_d;
  logic            is_read_q, is_read_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            read_q, read_d, write_q, write_d, begin_q, begin_d;
  logic            init_done_q, init_done_d, timeout_q, timeout_d, frame_q, frame_d;
  logic [7:0]      buf_q [32];
  logic [7:0]      buf_d [32];

  logic            iss, iss_read;
  logic [1:0]      iss_addr;
  logic [7:0]      iss_data;
  logic            setup_last, strobe_last, hold_last;
  logic            rdata_unused;

  // Only the busy flag matters; the address counter bits are ignored.
  assign rdata_unused = ^avm_readdata[6:0];

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  endfunction

  assign setup_last  = (phase_q == PH_SETUP)  && (pcnt_q == PH_W'(SETUP_CYCLES - 1));
  assign strobe_last = (phase_q == PH_STROBE) && (pcnt_q == PH_W'(E_CYCLES - 1));
  assign hold_last   = (phase_q == PH_HOLD)   && (pcnt_q == PH_W'(HOLD_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    caller_d    = caller_q;
    phase_d     = phase_q;
    pcnt_d      = pcnt_q;
    pw_cnt_d    = pw_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    init_idx_d  = init_idx_q;
    line_d      = line_q;
    col_d       = col_q;
    busy_d      = busy_q;
    is_read_d   = is_read_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_d      = read_q;
    write_d     = write_q;
    begin_d     = 1'b0;
    init_done_d = init_done_q;
    timeout_d   = timeout_q;
    frame_d     = 1'b0;
    buf_d       = buf_q;
    iss         = 1'b0;
    iss_read    = 1'b0;
    iss_addr    = ADDR_CMD;
    iss_data    = 8'h00;

    if (buf_we) buf_d[buf_addr] = buf_wdata;

    // Sequencer: picks the next access in the last HOLD cycle of the current one.
    case (state_q)
      PWR_WAIT: begin
        if (pw_cnt_q == PW_W'(POWERON_CYCLES - 1)) begin
          state_d    = INIT;
          init_idx_d = 2'd0;
          iss        = 1'b1;
          iss_data   = init_cmd(2'd0);
        end else begin
          pw_cnt_d = pw_cnt_q + PW_W'(1);
        end
      end
      default: begin
        if (hold_last) begin
          if (state_q != POLL) begin
            caller_d   = state_q;
            state_d    = POLL;
            poll_cnt_d = PL_W'(1);
            iss        = 1'b1;
            iss_read   = 1'b1;
            iss_addr   = ADDR_STATUS;
          end else if (busy_q && (poll_cnt_q < PL_W'(POLL_LIMIT))) begin
            poll_cnt_d = poll_cnt_q + PL_W'(1);
            iss        = 1'b1;
            iss_read   = 1'b1;
            iss_addr   = ADDR_STATUS;
          end else begin
            if (busy_q) timeout_d = 1'b1;
            iss = 1'b1;
            case (caller_q)
              INIT: begin
                if (init_idx_q == 2'd3) begin
                  init_done_d = 1'b1;
                  line_d      = 1'b0;
                  state_d     = LINE_ADDR;
                  iss_data    = 8'h80;
                end else begin
                  init_idx_d = init_idx_q + 2'd1;
                  state_d    = INIT;
                  iss_data   = init_cmd(init_idx_q + 2'd1);
                end
              end
              DATA: begin
                if (col_q != 4'd15) begin
                  col_d    = col_q + 4'd1;
                  state_d  = DATA;
                  iss_addr = ADDR_DATA;
                  iss_data = buf_q[{line_q, col_q + 4'd1}];
                end else if (!line_q) begin
                  line_d   = 1'b1;
                  state_d  = LINE_ADDR;
                  iss_data = 8'hC0;
                end else begin
                  // Frame complete: pulse while the next frame's line-1 address write starts.
                  frame_d  = 1'b1;
                  line_d   = 1'b0;
                  state_d  = FRAME;
                  iss_data = 8'h80;
                end
              end
              default: begin
                col_d    = 4'd0;
                state_d  = DATA;
                iss_addr = ADDR_DATA;
                iss_data = buf_q[{line_q, 4'd0}];
              end
            endcase
          end
        end
      end
    endcase

    // Access engine: SETUP -> STROBE -> HOLD.
    case (phase_q)
      PH_SETUP: begin
        if (setup_last) begin
          phase_d = PH_STROBE;
          pcnt_d  = '0;
          read_d  = is_read_q;
          write_d = !is_read_q;
          begin_d = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PH_W'(1);
        end
      end
      PH_STROBE: begin
        if (strobe_last) begin
          phase_d = PH_HOLD;
          pcnt_d  = '0;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (is_read_q) busy_d = avm_readdata[7];
        end else begin
          pcnt_d = pcnt_q + PH_W'(1);
        end
      end
      PH_HOLD: begin
        if (hold_last) begin
          phase_d = PH_IDLE;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + PH_W'(1);
        end
      end
      default: ;
    endcase

    if (iss) begin
      phase_d   = PH_SETUP;
      pcnt_d    = '0;
      is_read_d = iss_read;
      addr_d    = iss_addr;
      wdata_d   = iss_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PWR_WAIT;
      caller_q    <= PWR_WAIT;
      phase_q     <= PH_IDLE;
      pcnt_q      <= '0;
      pw_cnt_q    <= '0;
      poll_cnt_q  <= '0;
      init_idx_q  <= 2'd0;
      line_q      <= 1'b0;
      col_q       <= 4'd0;
      busy_q      <= 1'b0;
      is_read_q   <= 1'b0;
      addr_q      <= ADDR_CMD;
      wdata_q     <= 8'h00;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      begin_q     <= 1'b0;
      init_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      frame_q     <= 1'b0;
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else begin
      state_q     <= state_d;
      caller_q    <= caller_d;
      phase_q     <= phase_d;
      pcnt_q      <= pcnt_d;
      pw_cnt_q    <= pw_cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      init_idx_q  <= init_idx_d;
      line_q      <= line_d;
      col_q       <= col_d;
      busy_q      <= busy_d;
      is_read_q   <= is_read_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_q      <= read_d;
      write_q     <= write_d;
      begin_q     <= begin_d;
      init_done_q <= init_done_d;
      timeout_q   <= timeout_d;
      frame_q     <= frame_d;
      buf_q       <= buf_d;
    end
  end

  assign avm_address       = addr_q;
  assign avm_read          = read_q;
  assign avm_write         = write_q;
  assign avm_begintransfer = begin_q;
  assign avm_writedata     = wdata_q;
  assign init_done         = init_done_q;
  assign timeout_err       = timeout_q;
  assign frame_done        = frame_q;

endmodule

// File: tb/tb_lcd_refresh_master.sv
// Scoreboard bench for lcd_refresh_master: a reference model of the access sequence
// feeds an expected-access queue; a bus monitor pops and checks content and timing.
module tb_lcd_refresh_master;

  localparam int SETUP = 2;
  localparam int ECYC  = 12;
  localparam int HOLD  = 2;
  localparam int PWR   = 10;
  localparam int PLIM  = 5;
  localparam int ACC   = SETUP + ECYC + HOLD;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] avm_address;
  logic       avm_read, avm_write, avm_begintransfer;
  logic [7:0] avm_writedata;
  logic [7:0] avm_readdata = 8'h00;
  logic       buf_we;
  logic [4:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       init_done, timeout_err, frame_done;

  lcd_refresh_master #(
    .SETUP_CYCLES(SETUP), .E_CYCLES(ECYC), .HOLD_CYCLES(HOLD),
    .POWERON_CYCLES(PWR), .POLL_LIMIT(PLIM)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_begintransfer(avm_begintransfer), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .init_done(init_done), .timeout_err(timeout_err),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic [1:0] a;
    logic [7:0] d;
    logic       idn;
    logic       to;
    logic       fm;
  } acc_t;

  acc_t       exp_q[$];
  logic [7:0] resp_q[$];
  int         nchk = 0;
  int         nerr = 0;

  logic [7:0] mbuf [32];
  logic       m_init_done, m_timeout;
  bit         rand_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rand_busy();
    int r;
    if (!rand_mode) return 0;
    r = $urandom_range(0, 9);
    if (r < 5) return 0;
    if (r < 8) return r - 4;
    return 7;
  endfunction

  task automatic push_acc(input logic rd, input logic [1:0] a, input logic [7:0] d, input logic fm);
    acc_t e;
    e.rd = rd; e.a = a; e.d = d; e.idn = m_init_done; e.to = m_timeout; e.fm = fm;
    exp_q.push_back(e);
  endtask

  // b busy responses before ready; reads stop at the poll limit.
  task automatic push_poll(input int b);
    int n;
    n = (b < PLIM) ? b + 1 : PLIM;
    for (int i = 0; i < n; i++) begin
      push_acc(1'b1, 2'b01, 8'h00, 1'b0);
      if (i < b) resp_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
      else       resp_q.push_back(8'($urandom_range(0, 127)));
    end
    if (b >= PLIM) m_timeout = 1'b1;
  endtask

  task automatic push_write(input logic [1:0] a, input logic [7:0] d, input logic fm, input int b);
    push_acc(1'b0, a, d, fm);
    push_poll(b);
  endtask

  task automatic push_init(input int first_b);
    logic [7:0] cmds [4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h01; cmds[3] = 8'h06;
    for (int k = 0; k < 4; k++) push_write(2'b00, cmds[k], 1'b0, (k == 0) ? first_b : rand_busy());
    m_init_done = 1'b1;
  endtask

  task automatic push_frame(input logic fm);
    for (int ln = 0; ln < 2; ln++) begin
      push_write(2'b00, (ln == 0) ? 8'h80 : 8'hC0, (ln == 0) ? fm : 1'b0, rand_busy());
      for (int c = 0; c < 16; c++) push_write(2'b10, mbuf[ln*16 + c], 1'b0, rand_busy());
    end
  endtask

  // ---------------- slave: supplies queued status bytes ----------------
  always @(negedge clk) begin
    if (!reset_n) avm_readdata = 8'h00;
    else if (avm_begintransfer && avm_read)
      avm_readdata = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
  end

  // ---------------- monitor ----------------
  int         cyc, stb_run, win_left, last_bt, fd_cnt, fd_cyc;
  bit         have_bt, win_ok;
  logic       prev_stb, prev_fd, stb, rise;
  logic [9:0] hist1, hist2, cur, win_val;
  acc_t       me;

  always @(negedge clk) begin
    if (!reset_n) begin
      cyc = 0; stb_run = 0; win_left = 0; have_bt = 0; fd_cnt = 0;
      prev_stb = 0; prev_fd = 0; hist1 = '0; hist2 = '0;
    end else begin
      cyc++;
      cur = {avm_address, avm_writedata};
      stb = avm_read | avm_write;
      if (stb) chk("rw_exclusive", 32'(avm_read & avm_write), 32'd0);
      if (frame_done) begin
        chk("frame_done_width", 32'(prev_fd), 32'd0);
        fd_cnt++;
        fd_cyc = cyc;
      end
      if (stb) stb_run++;
      if (!stb && prev_stb) begin
        chk("strobe_width", 32'(stb_run), 32'(ECYC));
        stb_run = 0;
      end
      if (win_left > 0) begin
        if (cur != win_val) win_ok = 0;
        win_left--;
        if (win_left == 0) chk("addr_data_hold", 32'(win_ok), 32'd1);
      end
      rise = stb && !prev_stb;
      if (rise || avm_begintransfer) chk("begintransfer", 32'(avm_begintransfer), 32'(rise));
      if (avm_begintransfer) begin
        chk("addr_data_setup", 32'(hist1 == cur && hist2 == cur), 32'd1);
        if (have_bt) chk("access_spacing", 32'(cyc - last_bt), 32'(ACC));
        else         chk("first_strobe_cycle", 32'(cyc), 32'(PWR + SETUP));
        have_bt = 1; last_bt = cyc;
        win_val = cur; win_ok = 1; win_left = ECYC + HOLD - 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_access", {19'd0, avm_read, avm_address, avm_writedata, 2'd0}, 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("access", {19'd0, avm_read, avm_write, avm_address, avm_writedata, init_done, timeout_err},
                        {19'd0, me.rd, !me.rd, me.a, me.d, me.idn, me.to});
          chk("frame_done_pos", 32'(me.fm ? (fd_cnt == 1 && fd_cyc == cyc - SETUP) : (fd_cnt == 0)), 32'd1);
        end
        fd_cnt = 0;
      end
      hist2 = hist1; hist1 = cur; prev_stb = stb; prev_fd = frame_done;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] outs();
    return {16'd0, avm_address, avm_read, avm_write, avm_begintransfer, avm_writedata,
            init_done, timeout_err, frame_done};
  endfunction

  task automatic wait_frame(input int limit);
    int n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < limit);
    chk("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic host_write(input int idx, input logic [7:0] val);
    @(negedge clk);
    buf_we = 1'b1; buf_addr = 5'(idx); buf_wdata = val;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  initial begin
    int n;
    logic [7:0] v;
    reset_n = 1'b0; buf_we = 1'b0; buf_addr = '0; buf_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);

    // Phase 1: random buffer and busy pattern; first poll sees 3 busy reads.
    rand_mode = 1; m_init_done = 0; m_timeout = 0;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'($urandom_range(0, 255));
    push_init(3);
    push_frame(1'b0);
    @(negedge clk); #2 reset_n = 1'b1;
    for (int i = 0; i < 32; i++) host_write(i, mbuf[i]);
    chk("init_done_early", 32'(init_done), 32'd0);

    wait_frame(20000);
    // New line-2 text lands well before line 2 of the next frame is sent.
    for (int i = 16; i < 32; i++) mbuf[i] = 8'($urandom_range(0, 255));
    push_frame(1'b1);
    for (int i = 16; i < 32; i++) host_write(i, mbuf[i]);

    wait_frame(20000);
    push_frame(1'b1);

    // Reset in the middle of a data-write strobe.
    n = 0;
    do begin @(negedge clk); n++; end while (!(avm_write && avm_address == 2'b10) && n < 5000);
    chk("data_write_seen", 32'(avm_write && avm_address == 2'b10), 32'd1);
    #1 reset_n = 1'b0;
    #1 chk("reset_mid_strobe", outs(), 32'd0);
    exp_q.delete();
    resp_q.delete();

    // Phase 2: cleared buffer, first poll times out, no other busy.
    rand_mode = 0; m_init_done = 0; m_timeout = 0;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    push_init(7);
    push_frame(1'b0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("init_done_after_reset", 32'(init_done), 32'd0);
    chk("timeout_after_reset", 32'(timeout_err), 32'd0);
    wait_frame(20000);
    v = 8'(exp_q.size());
    chk("expected_drained", 32'(v), 32'd0);
    chk("responses_drained", 32'(resp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
